capture_dec: RTL and testbench
==============================

# capture_dec

Parametrised capture-and-decrement unit for the P1 datapath exercises. It samples an input word on a load strobe and holds the sampled original value. It then counts the working copy down to zero under an enable, flags completion with a one-cycle pulse, and always presents the combinational "current minus one" value. It is the clocked, width-generic successor of the single-bit decrement/hold block and is used as a loop/iteration counter by later P-stage controllers.

## Interface

Parameters:
- WIDTH, 8: width of the data input and of every data output; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture strobe; samples din this cycle.
- din  input  WIDTH  value to capture.
- en  input  1  count enable; ignored unless state is RUN.
- init_q  output  WIDTH  original value captured by the last load (registered).
- cnt  output  WIDTH  working counter value (registered).
- cnt_m1  output  WIDTH  cnt − 1 (combinational from cnt).
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle completion pulse, high exactly while state is DONE.

## Operation

- States: IDLE (encoding 0), RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are decoded from the state register and are glitch-free.
- Reset (asynchronous, any time, including mid-RUN):
  - state←IDLE, init_q←0, cnt←0.
  - Outputs are therefore busy=0, done=0, and cnt_m1 = all-ones (or 0 with saturation; see Configuration).
- load=1 in any state has priority over en and over all state transitions:
  - init_q←din and cnt←din.
  - If din≠0, next state is RUN.
  - If din=0, next state is DONE; this is a zero-length job and still produces one done pulse.
- RUN with load=0, en=1: cnt←cnt−1. If cnt==1 this cycle, next state is DONE (cnt becomes 0).
- RUN with load=0, en=0: hold all state.
- DONE with load=0: next state is IDLE unconditionally. cnt stays 0 and init_q holds.
- IDLE with load=0: hold; en has no effect.
- init_q changes only on load or reset and never during counting.
- Arithmetic: cnt_m1 = cnt − 1, modulo 2^WIDTH. din = all-ones is legal and counts 2^WIDTH − 1 steps.

## Timing

- Load latency: load sampled at edge k gives cnt = init_q = din and busy=1 after edge k, i.e. visible in cycle k+1.
- Count: one decrement per RUN cycle with en=1 at the edge. A job of N steps (N≥1) with en held high takes:
  - N cycles in RUN;
  - then 1 cycle in DONE.
  - busy is high for N cycles and done rises on the edge that makes cnt 0.
- done is high for exactly one cycle and is never asserted together with busy.
- load during DONE: the new job starts and the next state is RUN (or DONE if din=0). The pulse already showing is the only pulse for the old job.
- load during RUN aborts the current job without a done pulse for it.
- cnt_m1 is combinational and has zero latency relative to cnt.

## Configuration

- CAPTURE_DEC_SAT_EN defined: cnt_m1 saturates, so cnt_m1 = 0 when cnt = 0. Reset value of cnt_m1 is 0.
- CAPTURE_DEC_SAT_EN not defined: cnt_m1 wraps, so cnt_m1 = {WIDTH{1'b1}} when cnt = 0.
- The macro affects cnt_m1 only. The counter and FSM never decrement below 0 in either build.

## Test plan

- Reset: WIDTH=8, reset pulsed mid-cycle → immediately init_q=0, cnt=0, busy=0, done=0, cnt_m1=8'hFF (8'h00 with CAPTURE_DEC_SAT_EN).
- Basic count: load din=8'd3, then en=1 held → cnt reads 3,2,1 with busy=1 for 3 cycles. Next cycle cnt=0, done=1, busy=0. Then IDLE. init_q=3 throughout.
- Stall: load 8'd2, en pattern 1,0,0,1 → cnt reads 2,1,1,1, then 0 with done; busy is high for 4 cycles.
- Zero job: load din=0 → next cycle done=1, busy=0, cnt=0; following cycle IDLE.
- Abort/reload: load 8'd5, two enabled counts (cnt=3), then load 8'd1 → no done for the first job. Next cycle cnt=1, init_q=1, and one cycle later done=1.
- Wrap/width: WIDTH=4, load 4'hF with en held → 15 RUN cycles, then done. cnt_m1 at cnt=4'h0 equals 4'hF without the macro and 4'h0 with it.

Source files
------------

// File: rtl/capture_dec.sv
// Capture-and-decrement unit: captures din on load, counts a working copy to zero under en.
// Optional macro CAPTURE_DEC_SAT_EN makes cnt_m1 saturate at zero instead of wrapping.
module capture_dec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] init_q,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_m1,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] init_val_q, init_val_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            init_val_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_val_q <= init_val_d;
            cnt_q      <= cnt_d;
        end
    end

    // load overrides en and every transition, including from DONE
    always_comb begin
        state_d    = state_q;
        init_val_d = init_val_q;
        cnt_d      = cnt_q;
        if (load) begin
            init_val_d = din;
            cnt_d      = din;
            state_d    = (din != ZERO) ? RUN : DONE;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (en) begin
                        cnt_d = cnt_q - ONE;
                        if (cnt_q == ONE) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign init_q = init_val_q;
    assign cnt    = cnt_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

`ifdef CAPTURE_DEC_SAT_EN
    assign cnt_m1 = (cnt_q == ZERO) ? ZERO : (cnt_q - ONE);
`else
    assign cnt_m1 = cnt_q - ONE;
`endif

endmodule

// File: tb/tb_capture_dec.sv
// Directed vector bench for capture_dec: an 8-bit instance driven from a table,
// plus hand sequences for asynchronous reset and a 4-bit full-range wrap job.
module tb_capture_dec;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] din;
    logic       en;
    logic [7:0] init_q, cnt, cnt_m1;
    logic       busy, done;

    logic       load4;
    logic [3:0] din4;
    logic       en4;
    logic [3:0] init_q4, cnt4, cnt_m14;
    logic       busy4, done4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    capture_dec #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .load(load), .din(din), .en(en),
        .init_q(init_q), .cnt(cnt), .cnt_m1(cnt_m1), .busy(busy), .done(done)
    );

    capture_dec #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .load(load4), .din(din4), .en(en4),
        .init_q(init_q4), .cnt(cnt4), .cnt_m1(cnt_m14), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic       e;
        logic [7:0] x_cnt;
        logic [7:0] x_init;
        logic       x_busy;
        logic       x_done;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] m1_8(input logic [7:0] c);
`ifdef CAPTURE_DEC_SAT_EN
        return (c == 8'd0) ? 8'd0 : c - 8'd1;
`else
        return c - 8'd1;
`endif
    endfunction

    function automatic logic [3:0] m1_4(input logic [3:0] c);
`ifdef CAPTURE_DEC_SAT_EN
        return (c == 4'd0) ? 4'd0 : c - 4'd1;
`else
        return c - 4'd1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check8(input string tag);
        check({tag, ".idle_cnt"}, 32'(cnt), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".init"}, 32'(init_q), 32'd0);
        check({tag, ".cnt_m1"}, 32'(cnt_m1), 32'(m1_8(8'd0)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int runs;
        int seen_done;
        reset = 1'b1; load = 1'b0; din = '0; en = 1'b0;
        load4 = 1'b0; din4 = '0; en4 = 1'b0;
        #3;
        check8("rst");
        check("rst4.cnt_m1", 32'(cnt_m14), 32'(m1_4(4'd0)));
        check("rst4.busy", 32'(busy4), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // basic count 3
        vecs.push_back('{1'b1, 8'd3, 1'b0, 8'd3, 8'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd2, 8'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd1, 8'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd3, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0});
        // stall: en 1,0,0,1
        vecs.push_back('{1'b1, 8'd2, 1'b0, 8'd2, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd1, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd1, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd1, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd0, 8'd2, 1'b0, 1'b0});
        // zero-length job
        vecs.push_back('{1'b1, 8'd0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0});
        // abort and reload
        vecs.push_back('{1'b1, 8'd5, 1'b0, 8'd5, 8'd5, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd4, 8'd5, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd3, 8'd5, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'd1, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0});
        // load during DONE starts the next job immediately
        vecs.push_back('{1'b1, 8'd1, 1'b0, 8'd1, 8'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'd2, 1'b1, 8'd2, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd1, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 8'd2, 1'b0, 1'b0});
        // all-ones capture then abort with zero job
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'hFE, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            load = vecs[i].ld; din = vecs[i].d; en = vecs[i].e;
            tick();
            check({tag, ".cnt"}, 32'(cnt), 32'(vecs[i].x_cnt));
            check({tag, ".init"}, 32'(init_q), 32'(vecs[i].x_init));
            check({tag, ".busy"}, 32'(busy), 32'(vecs[i].x_busy));
            check({tag, ".done"}, 32'(done), 32'(vecs[i].x_done));
            check({tag, ".cnt_m1"}, 32'(cnt_m1), 32'(m1_8(vecs[i].x_cnt)));
        end

        // asynchronous reset in the middle of a running job
        load = 1'b1; din = 8'd5; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        check("midrun.cnt", 32'(cnt), 32'd4);
        #3;
        reset = 1'b1;
        #1;
        check8("midrst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        check8("postrst");

        // 4-bit full-range job: 15 RUN cycles then one DONE
        load4 = 1'b1; din4 = 4'hF; en4 = 1'b1;
        tick();
        load4 = 1'b0;
        check("w4.init", 32'(init_q4), 32'hF);
        check("w4.cnt_m1_top", 32'(cnt_m14), 32'hE);
        runs = 0;
        seen_done = 0;
        for (int c = 0; c < 40 && seen_done == 0; c++) begin
            if (busy4) runs++;
            if (done4) begin
                seen_done = 1;
                check("w4.cnt_at_done", 32'(cnt4), 32'd0);
                check("w4.cnt_m1_zero", 32'(cnt_m14), 32'(m1_4(4'd0)));
                check("w4.busy_at_done", 32'(busy4), 32'd0);
            end else begin
                tick();
            end
        end
        check("w4.done_seen", 32'(seen_done), 32'd1);
        check("w4.run_cycles", 32'(runs), 32'd15);
        tick();
        check("w4.idle_done", 32'(done4), 32'd0);
        check("w4.idle_busy", 32'(busy4), 32'd0);
        check("w4.init_hold", 32'(init_q4), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
